// File: rtl/move_pkg.sv
// Shared constants and slot state encoding for the 1-to-2 move demux buffer.
package move_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  localparam logic SEL_PORT0 = 1'b0;
  localparam logic SEL_PORT1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/move_slot.sv
// One-entry registered output slot with valid/ready handshake and a
// wrapping completed-transfer counter.
module move_slot
  import move_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fill_i,
  input  logic [WIDTH-1:0] fill_data_i,
  input  logic             ready_i,
  output logic             can_accept_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drain_s;

  assign drain_s      = (state_q == SLOT_FULL) && ready_i;
  // A full slot that drains this cycle can take a new word in the same cycle.
  assign can_accept_o = (state_q == SLOT_EMPTY) || drain_s;

  // Next-state, data reload and counter update for the slot.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (fill_i) begin
          state_d = SLOT_FULL;
          data_d  = fill_data_i;
        end else begin
          state_d = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (fill_i) begin
          state_d = SLOT_FULL;
          data_d  = fill_data_i;
        end else if (drain_s) begin
          state_d = SLOT_EMPTY;
        end else begin
          state_d = SLOT_FULL;
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
      end
    endcase
    if (drain_s) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Slot registers with synchronous reset that discards any buffered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      data_q  <= {WIDTH{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == SLOT_FULL);
  assign count_o = count_q;

endmodule

// File: rtl/move_demux_buf.sv
// 1-to-2 steering buffer: routes the source stream to the register-file
// (port 0) or memory (port 1) write-back slot chosen by in_select.
module move_demux_buf
  import move_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_select,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count
);

  logic acc0_s, acc1_s, sel_acc_s;
  logic fill0_s, fill1_s;

  // Head-of-line: only the selected slot's state decides acceptance.
  always_comb begin
    sel_acc_s = 1'b0;
    if (in_select == SEL_PORT1) begin
      sel_acc_s = acc1_s;
    end else begin
      sel_acc_s = acc0_s;
    end
    in_ready = !reset && sel_acc_s;
  end

  assign fill0_s = in_valid && in_ready && (in_select == SEL_PORT0);
  assign fill1_s = in_valid && in_ready && (in_select == SEL_PORT1);

  move_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk          (clk),
    .reset        (reset),
    .fill_i       (fill0_s),
    .fill_data_i  (in_data),
    .ready_i      (out0_ready),
    .can_accept_o (acc0_s),
    .data_o       (out0_data),
    .valid_o      (out0_valid),
    .count_o      (out0_count)
  );

  move_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk          (clk),
    .reset        (reset),
    .fill_i       (fill1_s),
    .fill_data_i  (in_data),
    .ready_i      (out1_ready),
    .can_accept_o (acc1_s),
    .data_o       (out1_data),
    .valid_o      (out1_valid),
    .count_o      (out1_count)
  );

endmodule

// File: tb/tb_move_demux_buf.sv
// Scoreboard bench for move_demux_buf: each slot is modelled as a capacity-1
// queue of accepted words plus a wrapping drain count.
module tb_move_demux_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_select = 1'b0;
  logic        in_ready;
  logic [31:0] out0_data, out1_data;
  logic        out0_valid, out1_valid;
  logic        out0_ready = 1'b0;
  logic        out1_ready = 1'b0;
  logic [15:0] out0_count, out1_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int  cnt0 = 0, cnt1 = 0;
  bit  zero0 = 1'b1, zero1 = 1'b1;
  bit  armed = 1'b0;

  move_demux_buf #(.WIDTH(32), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_select  (in_select),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs with the model, then retire handshakes that
  // the coming rising edge will complete.
  always @(negedge clk) begin
    bit exp_rdy;
    if (armed) begin
      chk("valid0", 32'(out0_valid), 32'(q0.size() != 0));
      chk("valid1", 32'(out1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0) chk("data0", out0_data, q0[0]);
      else if (zero0)     chk("data0_rst", out0_data, 32'd0);
      if (q1.size() != 0) chk("data1", out1_data, q1[0]);
      else if (zero1)     chk("data1_rst", out1_data, 32'd0);
      chk("count0", 32'(out0_count), 32'(cnt0));
      chk("count1", 32'(out1_count), 32'(cnt1));
    end
    if (reset) exp_rdy = 1'b0;
    else if (in_select) exp_rdy = (q1.size() == 0) || out1_ready;
    else exp_rdy = (q0.size() == 0) || out0_ready;
    if (armed || reset) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (reset) begin
      q0.delete(); q1.delete();
      cnt0 = 0; cnt1 = 0;
      zero0 = 1'b1; zero1 = 1'b1;
      armed = 1'b1;
    end else if (armed) begin
      if (q0.size() != 0 && out0_ready) begin
        void'(q0.pop_front());
        cnt0 = (cnt0 + 1) % 65536;
      end
      if (q1.size() != 0 && out1_ready) begin
        void'(q1.pop_front());
        cnt1 = (cnt1 + 1) % 65536;
      end
    end
  end

  // One clock of stimulus; an accepted word is pushed as the expected output.
  task automatic cycle(input bit rst, input bit v, input bit sel,
                       input logic [31:0] d, input bit r0, input bit r1);
    bit acc;
    @(posedge clk); #1;
    reset = rst; in_valid = v; in_select = sel; in_data = d;
    out0_ready = r0; out1_ready = r1;
    acc = v && !rst && (sel ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0));
    @(negedge clk); #1;
    if (acc) begin
      if (sel) begin q1.push_back(d); zero1 = 1'b0; end
      else     begin q0.push_back(d); zero0 = 1'b0; end
    end
  endtask

  task automatic idle(input bit r0, input bit r1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, r0, r1);
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    // Reset held two cycles with a word offered.
    cycle(1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_valid0", 32'(out0_valid), 32'd0);
    chk("rst_data1", out1_data, 32'd0);
    chk("rst_count0", 32'(out0_count), 32'd0);

    // Single route to port 0.
    cycle(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("route_valid0", 32'(out0_valid), 32'd1);
    chk("route_data0", out0_data, 32'hDEADBEEF);
    chk("route_valid1", 32'(out1_valid), 32'd0);
    idle(1'b1, 1'b0);
    chk("route_count0", 32'(out0_count), 32'd1);

    // Back-pressure on port 1.
    cycle(1'b0, 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h22222222, 1'b1, 1'b0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_hold_data1", out1_data, 32'h11111111);
    cycle(1'b0, 1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1);
    chk("bp_in_ready_high", 32'(in_ready), 32'd1);
    idle(1'b1, 1'b0);
    chk("bp_reload_data1", out1_data, 32'h22222222);
    chk("bp_count1_a", 32'(out1_count), 32'd1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("bp_count1_b", 32'(out1_count), 32'd2);

    // Head-of-line blocking.
    cycle(1'b0, 1'b1, 1'b0, 32'h33333333, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h44444444, 1'b0, 1'b1);
    chk("hol_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 32'h55555555, 1'b0, 1'b1);
    chk("hol_port1_empty", 32'(out1_valid), 32'd0);
    chk("hol_other_ready", 32'(in_ready), 32'd1);
    idle(1'b0, 1'b0);
    chk("hol_data1", out1_data, 32'h55555555);
    chk("hol_data0", out0_data, 32'h33333333);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);

    // Streaming after a fresh reset.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, i[0], 32'(i), 1'b1, 1'b1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("stream_count0", 32'(out0_count), 32'd4);
    chk("stream_count1", 32'(out1_count), 32'd4);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(63) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)),
            $urandom, $urandom_range(3) != 0, $urandom_range(3) != 0);
    end

    // Counter wrap on port 0.
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    for (int k = 0; k < 65535; k++) begin
      cycle(1'b0, 1'b1, 1'b0, $urandom, 1'b1, 1'b0);
    end
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("wrap_ffff", 32'(out0_count), 32'h0000FFFF);
    cycle(1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("wrap_zero", 32'(out0_count), 32'd0);

    // Reset with both slots full discards the words.
    cycle(1'b0, 1'b1, 1'b0, 32'hAAAA0000, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'hBBBB1111, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("mid_full0", 32'(out0_valid), 32'd1);
    chk("mid_full1", 32'(out1_valid), 32'd1);
    idle(1'b1, 1'b1);
    chk("mid_valid0", 32'(out0_valid), 32'd0);
    chk("mid_valid1", 32'(out1_valid), 32'd0);
    chk("mid_count1", 32'(out1_count), 32'd0);
    idle(1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_demux_buf.md
Name: move_demux_buf

Overview:
- 1-to-2 steering block, the write-side counterpart of the 32-bit 2:1 move mux: one 32-bit source stream is routed to one of two destination sinks by a select bit.
- Each destination has a registered one-entry output slot with a valid/ready handshake, so producer and sinks are decoupled by one pipeline stage.
- Sits between the datapath result bus and the two write-back consumers: register-file write port (port 0) and memory write port (port 1).

Parameters:
- WIDTH, 32, data width of input and both outputs.
- CNT_W, 16, width of per-port transfer counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  source data word.
- in_valid  input  1  source word present.
- in_select  input  1  destination: 0 = port 0, 1 = port 1; sampled with in_data.
- in_ready  output  1  block accepts the word this cycle.
- out0_data  output  WIDTH  port 0 registered data.
- out0_valid  output  1  port 0 slot full.
- out0_ready  input  1  port 0 sink accepts.
- out1_data  output  WIDTH  port 1 registered data.
- out1_valid  output  1  port 1 slot full.
- out1_ready  input  1  port 1 sink accepts.
- out0_count  output  CNT_W  port 0 completed transfers.
- out1_count  output  CNT_W  port 1 completed transfers.

Behaviour:
- Reset (synchronous): out0_valid = out1_valid = 0, out0_data = out1_data = 0, both counters = 0. Reset asserted mid-operation discards buffered words; in_ready is 0 during the reset cycle.
- Per-slot state machine, states EMPTY and FULL.
  - EMPTY -> FULL on fill.
  - FULL -> EMPTY on drain without fill.
  - FULL -> FULL on drain plus fill in the same cycle: the slot reloads with the new word and valid stays 1.
  - FULL holds on no drain.
- Drain for port N: outN_valid && outN_ready.
- Fill for port N: in_valid && in_ready && in_select == N.
- in_ready is combinational: the selected slot is EMPTY, or it is FULL and draining this cycle. Full throughput is one word per cycle per port.
- Ordering: the input is in-order, head-of-line blocking. If the selected slot is blocked, in_ready = 0 even when the other slot is EMPTY.
- Latency: a word accepted in cycle t appears on outN_data with outN_valid = 1 in cycle t+1.
- Stability: while outN_valid && !outN_ready, outN_data and outN_valid hold unchanged.
- Only the selected slot is written. The unselected slot's data and valid are unaffected by the input.
- Counters: outN_count increments by 1 on each drain of port N and wraps modulo 2^CNT_W (0xFFFF + 1 -> 0x0000). No saturation.
- in_data and in_select are ignored when in_valid = 0.
- A sink asserting outN_ready while outN_valid = 0 has no effect.

Decomposition:
- Package move_pkg:
  - WIDTH_DEF = 32, CNT_W_DEF = 16.
  - SEL_PORT0 = 1'b0, SEL_PORT1 = 1'b1.
  - slot state encoding SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1.
- Sub-module move_slot: one-entry register slot containing the EMPTY/FULL state, data register, drain detection and transfer counter. It exports its "can_accept" term. It is instantiated twice.
- The top level holds only the select decode and in_ready generation.

Test Plan:
- Reset then idle: reset high 2 cycles with in_valid = 1 -> out0_valid = out1_valid = 0, data 0, counters 0, in_ready = 0 during reset.
- Single route: in_data = 0xDEADBEEF, select 0, out0_ready = 1 -> cycle t+1: out0_valid = 1, out0_data = 0xDEADBEEF, out1_valid = 0; cycle t+2: out0_count = 1.
- Back-pressure: send 0x11111111 to port 1 with out1_ready = 0, then 0x22222222 to port 1 -> in_ready = 0 and out1_data holds 0x11111111. Raise out1_ready -> 0x22222222 accepted the same cycle and appears the next cycle; out1_count = 1 then 2.
- Head-of-line: port 0 slot full with out0_ready = 0, next word select 0, port 1 empty -> in_ready = 0 and port 1 stays empty. Then send a select 1 word -> accepted.
- Streaming: 8 consecutive words 0x0..0x7 alternating select, both ready = 1 -> in_ready = 1 every cycle. Port 0 sees 0,2,4,6 and port 1 sees 1,3,5,7, each one cycle late; counters reach 4 each.
- Wrap and mid-reset: preload counter to 0xFFFF via 65535 drains, one more drain -> 0x0000. Assert reset with both slots full -> both valids 0 the next cycle and the data is not delivered.
